// File: rtl/regfile_burst_master_if.sv
// Command / write-beat / read-beat channels between a burst agent and regfile_burst_master.
// Every channel transfers on a rising clk edge where valid && ready; valid never waits on ready.
interface regfile_burst_master_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 6
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;

  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;

  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output wr_valid, wr_data,
    output rd_ready,
    input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  wr_valid, wr_data,
    input  rd_ready,
    output cmd_ready, wr_ready, rd_valid, rd_data, rd_last
  );
endinterface

// File: rtl/regfile_burst_master.sv
// Burst initiator for a 2**ADDR_W x DATA_W register file: one read port, one write port,
// registered back-pressurable read response stream.
module regfile_burst_master #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  regfile_burst_master_if.slave bus,
  output logic              busy,
  output logic [ADDR_W-1:0] rf_read_adr,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic [ADDR_W-1:0] rf_write_adr,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_write_enable,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr_cnt;
  logic [LEN_W-1:0]  beats_left;
  logic              rd_valid_q;
  logic              rd_last_q;
  logic [DATA_W-1:0] rd_data_q;

  logic cmd_fire;
  logic wr_fire;
  logic capture;
  logic last_beat;

  // A read beat is captured whenever the output slot is empty or being drained this cycle.
  always_comb begin
    cmd_fire  = (state == IDLE) && bus.cmd_valid;
    wr_fire   = (state == WRITE) && bus.wr_valid;
    capture   = (state == READ) && (!rd_valid_q || bus.rd_ready);
    last_beat = (beats_left == '0);
  end

  always_comb begin
    state_nxt       = state;
    bus.cmd_ready   = 1'b0;
    bus.wr_ready    = 1'b0;
    rf_write_enable = 1'b0;
    case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) state_nxt = bus.cmd_write ? WRITE : READ;
      end
      WRITE: begin
        bus.wr_ready    = 1'b1;
        rf_write_enable = bus.wr_valid;
        if (wr_fire && last_beat) state_nxt = IDLE;
      end
      READ: begin
        if (capture && last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_cnt   <= '0;
      beats_left <= '0;
    end else if (cmd_fire) begin
      addr_cnt   <= bus.cmd_addr;
      beats_left <= bus.cmd_len;
    end else if (wr_fire || capture) begin
      addr_cnt <= addr_cnt + ADDR_ONE;
      if (!last_beat) beats_left <= beats_left - LEN_ONE;
    end
  end

  // rd_data is left untouched on drain so the last value stays visible for debug.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
    end else if (capture) begin
      rd_valid_q <= 1'b1;
      rd_last_q  <= last_beat;
      rd_data_q  <= rf_read_data;
    end else if (bus.rd_ready) begin
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end
  end

  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_last   = rd_last_q;
  assign bus.rd_data   = rd_data_q;
  assign rf_read_adr   = addr_cnt;
  assign rf_write_adr  = addr_cnt;
  assign rf_write_data = bus.wr_data;
  assign busy          = (state != IDLE) || rd_valid_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_regfile_burst_master.sv
// Directed bench for regfile_burst_master with a behavioural 64x64 register file model.
module tb_regfile_burst_master;

  logic        clk;
  logic        rst_n;
  logic        busy;
  logic [5:0]  rf_read_adr;
  logic [63:0] rf_read_data;
  logic [5:0]  rf_write_adr;
  logic [63:0] rf_write_data;
  logic        rf_write_enable;
  logic [1:0]  dbg_state;

  logic [63:0] regs [64];
  logic        load_pattern;
  int          wr_count;

  logic [63:0] exp_q[$];
  int          n_cmp;
  int          n_err;

  regfile_burst_master_if #(.ADDR_W(6), .DATA_W(64), .LEN_W(6)) bus ();

  regfile_burst_master #(.ADDR_W(6), .DATA_W(64), .LEN_W(6)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus.slave),
    .busy            (busy),
    .rf_read_adr     (rf_read_adr),
    .rf_read_data    (rf_read_data),
    .rf_write_adr    (rf_write_adr),
    .rf_write_data   (rf_write_data),
    .rf_write_enable (rf_write_enable),
    .dbg_state       (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  function automatic logic [63:0] pat(input int i);
    return {32'hDEADBEEF, 32'(i)};
  endfunction

  // register file model: combinational read, write on rising edge
  always @(posedge clk) begin
    if (load_pattern) begin
      for (int i = 0; i < 64; i++) regs[i] <= pat(i);
      wr_count <= 0;
    end else if (rf_write_enable) begin
      regs[rf_write_adr] <= rf_write_data;
      wr_count <= wr_count + 1;
    end
  end
  assign rf_read_data = regs[rf_read_adr];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks: called at a negedge, return at a negedge
  task automatic start_cmd(input logic wr, input logic [5:0] addr, input logic [5:0] len);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    #1;
    check("cmd_ready_idle", 64'(bus.cmd_ready), 64'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  // scoreboard-driven read burst; expected beats preloaded into exp_q
  task automatic run_read(input string tag, input logic [5:0] addr, input logic [5:0] len,
                          input bit stall);
    int          got;
    int          k;
    bit          rdy;
    bit          prev_hold;
    logic [63:0] prev_data;
    logic [63:0] exp;
    bus.rd_ready = 1'b1;
    start_cmd(1'b0, addr, len);
    #1;
    check({tag, "_latency_rd_valid"}, 64'(bus.rd_valid), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    got = 0;
    k = 0;
    prev_hold = 1'b0;
    prev_data = '0;
    while (got < int'(len) + 1 && k < 40) begin
      rdy = stall ? (k % 3 == 0) : 1'b1;
      bus.rd_ready = rdy;
      if (prev_hold) begin
        check({tag, "_hold_valid"}, 64'(bus.rd_valid), 64'd1);
        check({tag, "_hold_data"}, bus.rd_data, prev_data);
      end
      if (bus.rd_valid && rdy) begin
        exp = exp_q.pop_front();
        check({tag, "_data"}, bus.rd_data, exp);
        check({tag, "_last"}, 64'(bus.rd_last), 64'(got == int'(len)));
        got++;
      end
      prev_hold = bus.rd_valid && !rdy;
      prev_data = bus.rd_data;
      @(negedge clk);
      k++;
    end
    check({tag, "_beat_count"}, 64'(got), 64'(int'(len) + 1));
    #1;
    check({tag, "_drained_rd_valid"}, 64'(bus.rd_valid), 64'd0);
    check({tag, "_drained_busy"}, 64'(busy), 64'd0);
    check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  logic [63:0] a_data [4];
  logic [63:0] b_data [2];
  logic [3:0]  gap;
  int          beat;
  int          cnt0;

  initial begin
    n_cmp = 0;
    n_err = 0;
    a_data[0] = 64'hA000_0000_0000_00A0;
    a_data[1] = 64'hA111_1111_1111_11A1;
    a_data[2] = 64'hA222_2222_2222_22A2;
    a_data[3] = 64'hA333_3333_3333_33A3;
    b_data[0] = 64'hB0B0_B0B0_0000_0001;
    b_data[1] = 64'hB1B1_B1B1_0000_0002;
    gap = 4'b1001;

    rst_n         = 1'b0;
    load_pattern  = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_ready  = 1'b0;
    repeat (2) @(negedge clk);
    load_pattern = 1'b0;

    // reset state
    check("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    check("rst_rd_last", 64'(bus.rd_last), 64'd0);
    check("rst_rd_data", bus.rd_data, 64'd0);
    check("rst_we", 64'(rf_write_enable), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("idle_wr_ready", 64'(bus.wr_ready), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_rd_valid", 64'(bus.rd_valid), 64'd0);

    // write burst addr=5 len=3, wr_valid held high
    cnt0 = wr_count;
    start_cmd(1'b1, 6'd5, 6'd3);
    for (int i = 0; i < 4; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = a_data[i];
      #1;
      check("wr_ready", 64'(bus.wr_ready), 64'd1);
      check("wr_cmd_ready", 64'(bus.cmd_ready), 64'd0);
      check("wr_we", 64'(rf_write_enable), 64'd1);
      check("wr_adr", 64'(rf_write_adr), 64'(5 + i));
      check("wr_data_pass", rf_write_data, a_data[i]);
      @(negedge clk);
    end
    bus.wr_valid = 1'b0;
    #1;
    check("wr_done_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("wr_done_busy", 64'(busy), 64'd0);
    check("wr_count", 64'(wr_count - cnt0), 64'd4);
    check("wr_reg4_untouched", regs[4], pat(4));
    for (int i = 0; i < 4; i++) check("wr_reg_content", regs[5 + i], a_data[i]);
    check("wr_reg9_untouched", regs[9], pat(9));

    // read back regs 5..8
    for (int i = 0; i < 4; i++) exp_q.push_back(a_data[i]);
    run_read("rd_back", 6'd5, 6'd3, 1'b0);

    // read wrapping 62,63,0,1
    exp_q.push_back(pat(62));
    exp_q.push_back(pat(63));
    exp_q.push_back(pat(0));
    exp_q.push_back(pat(1));
    run_read("rd_wrap", 6'd62, 6'd3, 1'b0);

    // read with back-pressure pattern 1,0,0,...
    exp_q.push_back(pat(10));
    exp_q.push_back(pat(11));
    exp_q.push_back(pat(12));
    run_read("rd_stall", 6'd10, 6'd2, 1'b1);

    // gapped write len=1 at addr 20, wr_valid 1,0,0,1
    cnt0 = wr_count;
    start_cmd(1'b1, 6'd20, 6'd1);
    beat = 0;
    for (int k = 0; k < 4; k++) begin
      bus.wr_valid = gap[3 - k];
      bus.wr_data  = gap[3 - k] ? b_data[beat] : 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      check("gap_wr_ready", 64'(bus.wr_ready), 64'd1);
      check("gap_we", 64'(rf_write_enable), 64'(gap[3 - k]));
      if (gap[3 - k]) begin
        check("gap_adr", 64'(rf_write_adr), 64'(20 + beat));
        beat++;
      end
      @(negedge clk);
    end
    bus.wr_valid = 1'b0;
    #1;
    check("gap_done_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("gap_wr_count", 64'(wr_count - cnt0), 64'd2);
    check("gap_reg20", regs[20], b_data[0]);
    check("gap_reg21", regs[21], b_data[1]);
    check("gap_reg22_untouched", regs[22], pat(22));

    // reset during 2nd beat of a 4-beat write at addr 40
    start_cmd(1'b1, 6'd40, 6'd3);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 64'hC0C0_C0C0_C0C0_C0C0;
    #1;
    check("rstw_adr0", 64'(rf_write_adr), 64'd40);
    @(negedge clk);
    bus.wr_data = 64'hC1C1_C1C1_C1C1_C1C1;
    #1;
    check("rstw_adr1", 64'(rf_write_adr), 64'd41);
    rst_n = 1'b0;
    #1;
    check("rstw_we", 64'(rf_write_enable), 64'd0);
    check("rstw_state", 64'(dbg_state), 64'd0);
    check("rstw_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("rstw_busy", 64'(busy), 64'd0);
    check("rstw_rd_valid", 64'(bus.rd_valid), 64'd0);
    cnt0 = wr_count;
    @(negedge clk);
    check("rstw_no_write", 64'(wr_count - cnt0), 64'd0);
    bus.wr_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("rstw_reg40", regs[40], 64'hC0C0_C0C0_C0C0_C0C0);
    check("rstw_reg41", regs[41], pat(41));
    check("rstw_reg42", regs[42], pat(42));
    check("rstw_reg43", regs[43], pat(43));
    check("rstw_idle", 64'(bus.cmd_ready), 64'd1);

    // reset drops a pending read beat
    bus.rd_ready = 1'b0;
    start_cmd(1'b0, 6'd30, 6'd0);
    @(negedge clk);
    check("rstr_valid", 64'(bus.rd_valid), 64'd1);
    check("rstr_data", bus.rd_data, pat(30));
    check("rstr_last", 64'(bus.rd_last), 64'd1);
    check("rstr_busy_pending", 64'(busy), 64'd1);
    @(negedge clk);
    check("rstr_hold_data", bus.rd_data, pat(30));
    rst_n = 1'b0;
    #1;
    check("rstr_dropped_valid", 64'(bus.rd_valid), 64'd0);
    check("rstr_dropped_data", bus.rd_data, 64'd0);
    check("rstr_dropped_last", 64'(bus.rd_last), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
